conv2d_layer_controller: RTL and testbench

- Sequences one Conv2D layer around the address generator, weight/input buffers, four MAC lanes and the output buffer.
- Handles the start/busy/done handshake with the host FSM.
- Enables and stalls the address generator, and re-times its clear, address and valid strobes to the buffer read latency as MAC-side controls.
- Counts output pixels and kernel groups, generates lane write strobes, and flags malformed accumulation windows.

---
 rtl/conv2d_layer_controller_pkg.sv | 45 ++++
 rtl/conv2d_layer_controller_delay.sv | 27 ++
 rtl/conv2d_layer_controller.sv | 188 ++++++++++++++++++
 tb/tb_conv2d_layer_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_layer_controller_pkg.sv
// Shared types and helpers for the Conv2D layer controller: FSM encoding,
// geometry helpers that derive the layer constants, and the lane mask.
package conv2d_pkg;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTART,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } ctrl_state_t;

  // Output feature map size along one axis (OUT_W / OUT_H).
  function automatic int out_dim(input int in_size, input int pad, input int k, input int stride);
    return (in_size + 2 * pad - k) / stride + 1;
  endfunction

  // Accumulations per output pixel (MACS = K*K*C).
  function automatic int mac_total(input int k, input int channels);
    return k * k * channels;
  endfunction

  // Kernel groups covered by the MAC lanes (GROUPS = ceil(KERNELS/LANES)).
  function automatic int group_total(input int kernels);
    return (kernels + LANES - 1) / LANES;
  endfunction

  // Thermometer write mask for the kernels still remaining in this group.
  function automatic logic [3:0] lane_mask(input int remaining);
    if (remaining >= 4)
      return 4'b1111;
    else if (remaining == 3)
      return 4'b0111;
    else if (remaining == 2)
      return 4'b0011;
    else if (remaining == 1)
      return 4'b0001;
    else
      return 4'b0000;
  endfunction

endpackage

// File: rtl/conv2d_layer_controller_delay.sv
// N-cycle, W-bit strobe shift register used to re-time generator strobes
// to the buffer read latency. Holds its contents while i_shift is low.
module strobe_delay_line #(
  parameter int N = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_shift,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_stage[i] <= '0;
    end else if (i_shift) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[N-1];

endmodule

// File: rtl/conv2d_layer_controller.sv
// Sequences one Conv2D layer: host handshake, address generator enable/stall,
// MAC-side strobe re-timing, pixel/group counting and lane write strobes.
module conv2d_layer_controller
  import conv2d_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int KERNELS      = 4,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 0,
  parameter int INPUT_WIDTH  = 5,
  parameter int INPUT_HEIGHT = 5,
  parameter int CHANNELS     = 3,
  parameter int READ_LATENCY = 1,
  localparam int LYR_PIXELS  = out_dim(INPUT_WIDTH, PADDING, KERNEL_SIZE, STRIDE)
                             * out_dim(INPUT_HEIGHT, PADDING, KERNEL_SIZE, STRIDE),
  localparam int LYR_GROUPS  = group_total(KERNELS),
  localparam int PIX_W       = $clog2(LYR_PIXELS + 1),
  localparam int GRP_W       = $clog2(LYR_GROUPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             agu_restart,
  output logic             agu_enable,
  input  logic             agu_clear,
  input  logic             agu_addr_phase,
  input  logic             agu_valid,
  output logic             mac_clear,
  output logic             mac_en,
  output logic [3:0]       out_write,
  output logic [PIX_W-1:0] pixel_count,
  output logic [GRP_W-1:0] group_index,
  output logic             err_mac_count
);

  localparam int LYR_MACS = mac_total(KERNEL_SIZE, CHANNELS);
  localparam int MAC_W    = $clog2(LYR_MACS + 1);
  localparam int DRN_W    = $clog2(READ_LATENCY + 1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_next;
  logic [MAC_W-1:0] r_mac_cnt;
  logic [MAC_W-1:0] w_mac_cnt_next;
  logic [DRN_W-1:0] r_drain_cnt;
  logic [PIX_W-1:0] r_pix;
  logic [GRP_W-1:0] r_grp;
  logic             r_err;
  logic             w_mac_mismatch;
  logic             w_last_pixel;
  logic             w_last_group;
  logic             w_drain_last;
  logic             w_pipe_shift;

  // Count as it will stand after this cycle's strobes; clear wins first so
  // a clear coinciding with an address phase loads 1.
  always_comb begin
    w_mac_cnt_next = r_mac_cnt;
    if (agu_clear)
      w_mac_cnt_next = '0;
    if (agu_addr_phase && (w_mac_cnt_next != {MAC_W{1'b1}}))
      w_mac_cnt_next = w_mac_cnt_next + 1'b1;
  end

  assign w_mac_mismatch = (w_mac_cnt_next != MAC_W'(LYR_MACS));
  assign w_last_pixel   = (r_pix == PIX_W'(LYR_PIXELS - 1));
  assign w_last_group   = (r_grp == GRP_W'(LYR_GROUPS - 1));
  assign w_drain_last   = (r_drain_cnt == DRN_W'(READ_LATENCY - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    agu_restart  = 1'b0;
    agu_enable   = 1'b0;
    out_write    = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (start)
          w_state_next = ST_RESTART;
      end
      ST_RESTART: begin
        busy         = 1'b1;
        agu_restart  = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        agu_enable = 1'b1;
        if (agu_valid)
          w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_drain_last)
          w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        out_write = lane_mask(KERNELS - LANES * int'(r_grp));
        if (w_last_pixel && w_last_group)
          w_state_next = ST_DONE;
        else
          w_state_next = ST_RUN;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mac_cnt   <= '0;
      r_drain_cnt <= '0;
      r_pix       <= '0;
      r_grp       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mac_cnt <= '0;
            r_pix     <= '0;
            r_grp     <= '0;
            r_err     <= 1'b0;
          end
        end
        ST_RUN: begin
          r_mac_cnt   <= w_mac_cnt_next;
          r_drain_cnt <= '0;
          if (agu_valid && w_mac_mismatch)
            r_err <= 1'b1;
        end
        ST_DRAIN: r_drain_cnt <= r_drain_cnt + 1'b1;
        ST_WRITE: begin
          if (w_last_pixel) begin
            r_pix <= '0;
            r_grp <= r_grp + 1'b1;
          end else begin
            r_pix <= r_pix + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipes freeze only in IDLE so a window tail drains while the generator stalls.
  assign w_pipe_shift = (r_state != ST_IDLE);

  strobe_delay_line #(
    .N(READ_LATENCY),
    .W(1)
  ) u_clear_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_shift(w_pipe_shift),
    .i_d    (agu_clear),
    .o_q    (mac_clear)
  );

  strobe_delay_line #(
    .N(READ_LATENCY),
    .W(1)
  ) u_en_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_shift(w_pipe_shift),
    .i_d    (agu_addr_phase),
    .o_q    (mac_en)
  );

  assign pixel_count   = r_pix;
  assign group_index   = r_grp;
  assign err_mac_count = r_err;

endmodule

// File: tb/tb_conv2d_layer_controller.sv
// Bench for conv2d_layer_controller: two instances (default, and KERNELS=6 with
// READ_LATENCY=3), each driven by a behavioural address generator.
module tb_conv2d_layer_controller;

  typedef struct {
    int         inst;
    int         drop;
    int         hold;
    bit         drain_pulse;
    int         exp_writes;
    logic [3:0] exp_mask0;
    logic [3:0] exp_mask1;
    int         exp_grp;
    bit         exp_err;
    int         exp_macen;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_v;
  logic [1:0] busy_v, done_v, restart_v, en_v;
  logic [1:0] clr_v, ph_v, vld_v;
  logic [1:0] mclr_v, men_v, err_v;
  logic [7:0] ow_flat;
  logic [7:0] pix_flat;
  logic [3:0] grp_flat;

  int checks = 0;
  int errors = 0;
  int drop_win [2] = '{-1, -1};
  int prev_err [2] = '{0, 0};
  vec_t vecs [6];

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int KER_G = (gi == 0) ? 4 : 6;
      localparam int RL_G  = (gi == 0) ? 1 : 3;
      localparam int GRP_G = (KER_G + 3) / 4;

      logic [$clog2(GRP_G+1)-1:0] grp_l;
      int   step_r;
      int   win_r;
      logic ph_hist  [4];
      logic clr_hist [4];

      conv2d_layer_controller #(
        .KERNELS     (KER_G),
        .READ_LATENCY(RL_G)
      ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_v[gi]),
        .busy          (busy_v[gi]),
        .done          (done_v[gi]),
        .agu_restart   (restart_v[gi]),
        .agu_enable    (en_v[gi]),
        .agu_clear     (clr_v[gi]),
        .agu_addr_phase(ph_v[gi]),
        .agu_valid     (vld_v[gi]),
        .mac_clear     (mclr_v[gi]),
        .mac_en        (men_v[gi]),
        .out_write     (ow_flat[gi*4 +: 4]),
        .pixel_count   (pix_flat[gi*4 +: 4]),
        .group_index   (grp_l),
        .err_mac_count (err_v[gi])
      );

      assign grp_flat[gi*2 +: 2] = 2'(grp_l);

      // Generator model: step 0 clear, steps 1..27 address phase, step 28 valid.
      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          step_r <= 0;
          win_r  <= 0;
        end else if (restart_v[gi]) begin
          step_r <= 0;
          win_r  <= 0;
        end else if (en_v[gi]) begin
          if (step_r == 28) begin
            step_r <= 0;
            win_r  <= win_r + 1;
          end else begin
            step_r <= step_r + 1;
          end
        end
      end

      assign clr_v[gi] = en_v[gi] && (step_r == 0);
      assign ph_v[gi]  = en_v[gi] && (step_r >= 1) && (step_r <= 27)
                         && !((win_r == drop_win[gi]) && (step_r == 5));
      assign vld_v[gi] = en_v[gi] && (step_r == 28);

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 4; i++) begin
            ph_hist[i]  <= 1'b0;
            clr_hist[i] <= 1'b0;
          end
        end else begin
          ph_hist[0]  <= ph_v[gi];
          clr_hist[0] <= clr_v[gi];
          for (int i = 1; i < 4; i++) begin
            ph_hist[i]  <= ph_hist[i-1];
            clr_hist[i] <= clr_hist[i-1];
          end
        end
      end

      always @(negedge clk) begin
        if (rst_n) begin
          check($sformatf("mac_en_mirror%0d", gi), men_v[gi], ph_hist[RL_G-1]);
          check($sformatf("mac_clear_mirror%0d", gi), mclr_v[gi], clr_hist[RL_G-1]);
        end
      end
    end
  endgenerate

  task automatic run_layer(input vec_t v);
    int inst, rl, cyc, writes, restarts, macen, pend, pend_in, extra, k;
    bit seen_done, dp_done;
    logic [3:0] ow, exp_mask;
    inst = v.inst;
    rl = (inst == 0) ? 1 : 3;
    cyc = 0; writes = 0; restarts = 0; macen = 0; pend = 0; extra = 0;
    seen_done = 1'b0; dp_done = 1'b0;
    @(negedge clk);
    check("err_hold", err_v[inst], prev_err[inst]);
    drop_win[inst] = v.drop;
    start_v[inst] = 1'b1;
    while (!seen_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc >= v.hold) start_v[inst] = 1'b0;
      ow = ow_flat[inst*4 +: 4];
      if (restart_v[inst]) begin
        restarts++;
        check("err_clear_on_start", err_v[inst], 0);
      end
      if (men_v[inst]) macen++;
      pend_in = pend;
      if (pend > 0) begin
        check("drain_enable_low", en_v[inst], 0);
        pend--;
      end
      if (pend_in == 1 || ow != 4'b0000) begin
        k = writes;
        exp_mask = (k < 9) ? v.exp_mask0 : v.exp_mask1;
        check("write_timing", pend_in, 1);
        check("write_mask", ow, exp_mask);
        check("write_pixel", pix_flat[inst*4 +: 4], k % 9);
        check("write_group", grp_flat[inst*2 +: 2], k / 9);
        check("write_err", err_v[inst], (v.drop >= 0 && k >= v.drop) ? 1 : 0);
        $display("write inst=%0d n=%0d mask=%b pix=%0d grp=%0d err=%0d",
                 inst, k, ow, pix_flat[inst*4 +: 4], grp_flat[inst*2 +: 2], err_v[inst]);
        writes++;
      end
      if (en_v[inst] && vld_v[inst]) pend = rl + 1;
      if (v.drain_pulse && !dp_done && writes == 5 && pend == rl && pend_in == rl + 1) begin
        start_v[inst] = 1'b1;
        dp_done = 1'b1;
      end
      if (done_v[inst]) begin
        seen_done = 1'b1;
        check("done_writes", writes, v.exp_writes);
        check("done_group", grp_flat[inst*2 +: 2], v.exp_grp);
        check("done_pixel", pix_flat[inst*4 +: 4], 0);
        check("done_err", err_v[inst], v.exp_err);
        check("done_busy", busy_v[inst], 0);
        check("done_restarts", restarts, 1);
        check("done_mac_en_count", macen, v.exp_macen);
      end else begin
        check("busy_during_layer", busy_v[inst], 1);
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    repeat (25) begin
      @(negedge clk);
      start_v[inst] = 1'b0;
      extra += int'(done_v[inst]) + int'(restart_v[inst]) + int'(busy_v[inst])
             + int'(ow_flat[inst*4 +: 4] != 4'b0000);
    end
    check("quiet_after_done", extra, 0);
    $display("layer inst=%0d writes=%0d mac_en=%0d err=%0d", inst, writes, macen, err_v[0 + inst]);
    prev_err[inst] = v.exp_err;
  endtask

  task automatic reset_midrun();
    int writes, cyc, extra;
    writes = 0; cyc = 0; extra = 0;
    @(negedge clk);
    drop_win[0] = -1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (writes < 4 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (ow_flat[3:0] != 4'b0000) writes++;
    end
    check("rst_reach_window5", writes, 4);
    repeat (12) @(negedge clk);
    check("rst_pre_in_run", en_v[0], 1);
    check("rst_pre_pixel", pix_flat[3:0], 4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {busy_v[0], done_v[0], restart_v[0], en_v[0],
                            mclr_v[0], men_v[0], err_v[0], ow_flat[3:0]}, 0);
    check("rst_async_pixel", pix_flat[3:0], 0);
    check("rst_async_group", grp_flat[1:0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      extra += int'(ow_flat[3:0] != 4'b0000) + int'(busy_v[0]) + int'(en_v[0]);
    end
    check("rst_no_write_after", extra, 0);
    $display("reset mid-window done");
    prev_err[0] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start_v = 2'b00;
    //            inst drop hold dp  wr  m0     m1     grp err macen
    vecs[0] = '{0, -1,  1, 1'b0,  9, 4'hF, 4'h0, 1, 1'b0, 243};
    vecs[1] = '{1, -1,  1, 1'b0, 18, 4'hF, 4'h3, 2, 1'b0, 486};
    vecs[2] = '{0,  3,  1, 1'b0,  9, 4'hF, 4'h0, 1, 1'b1, 242};
    vecs[3] = '{0, -1,  1, 1'b0,  9, 4'hF, 4'h0, 1, 1'b0, 243};
    vecs[4] = '{0, -1, 60, 1'b1,  9, 4'hF, 4'h0, 1, 1'b0, 243};
    vecs[5] = '{0, -1,  1, 1'b0,  9, 4'hF, 4'h0, 1, 1'b0, 243};
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ctl", {busy_v[i], done_v[i], restart_v[i], en_v[i],
                          mclr_v[i], men_v[i], err_v[i], ow_flat[i*4 +: 4]}, 0);
      check("reset_pixel", pix_flat[i*4 +: 4], 0);
      check("reset_group", grp_flat[i*2 +: 2], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy_v, en_v, restart_v}, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) reset_midrun();
      run_layer(vecs[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
